// File: rtl/rr_request_agent.sv
// rr_request_agent
//
// Client-side companion of a 4-way round-robin fixed-time-slice arbiter.
// Each client keeps a count of queued jobs; every job consumes exactly one
// uninterrupted grant slot of SLOT cycles and is retired when that slot
// completes. The agent also watches the grant vector for protocol
// violations and records them in sticky error flags.
//
// Ports
//   clk          clock, all state changes on the rising edge
//   rst          asynchronous active-high reset
//   push[N]      per-client: enqueue one job this cycle
//   full[N]      per-client: pending count at its maximum (2^CW-1)
//   req[N]       to arbiter: client has at least one pending job
//   gnt[N]       from arbiter: grant vector
//   done[N]      per-client one-cycle pulse: a job retired on the last edge
//   busy[N]      per-client: currently inside a grant slot
//   clr_err      synchronous clear of all sticky error flags
//   err_multi    sticky: more than one grant bit set
//   err_spurious sticky: grant to a client with nothing pending
//   err_short    sticky: grant removed before the slot completed
//   err_ovf      sticky: push dropped because the client was full

module rr_request_agent #(
  parameter int N    = 4,
  parameter int CW   = 3,
  parameter int SLOT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] push,
  output logic [N-1:0] full,
  output logic [N-1:0] req,
  input  logic [N-1:0] gnt,
  output logic [N-1:0] done,
  output logic [N-1:0] busy,
  input  logic         clr_err,
  output logic         err_multi,
  output logic         err_spurious,
  output logic         err_short,
  output logic         err_ovf
);

  // Hold counter needs to reach SLOT-1; keep at least one bit for SLOT=1.
  localparam int HW = (SLOT > 1) ? $clog2(SLOT) : 1;
  localparam logic [CW-1:0] PMAX  = '1;
  localparam logic [HW-1:0] HLAST = HW'(SLOT - 1);

  logic [N-1:0][CW-1:0] pending_q;
  logic [N-1:0][CW-1:0] pending_d;
  logic [N-1:0][HW-1:0] hold_q;
  logic [N-1:0][HW-1:0] hold_d;
  logic [N-1:0]         retire;
  logic [N-1:0]         spur_hit;
  logic [N-1:0]         short_hit;
  logic [N-1:0]         ovf_hit;
  logic                 multi_hit;

  // Per-client next-state logic. A granted client with work advances its
  // hold count and retires a job on the last cycle of the slot. A grant that
  // disappears mid-slot abandons the slot without retiring the job, so the
  // job stays pending and will be re-served by a later full slot. A retire
  // frees one entry in the same cycle, which is why a push into a full
  // client is still accepted when it coincides with a retire.
  always_comb begin
    full      = '0;
    req       = '0;
    busy      = '0;
    retire    = '0;
    spur_hit  = '0;
    short_hit = '0;
    ovf_hit   = '0;
    pending_d = pending_q;
    hold_d    = hold_q;
    for (int i = 0; i < N; i++) begin
      full[i] = (pending_q[i] == PMAX);
      req[i]  = (pending_q[i] != '0);
      busy[i] = (hold_q[i] != '0);

      spur_hit[i]  = gnt[i] && !req[i];
      short_hit[i] = !gnt[i] && busy[i];
      retire[i]    = gnt[i] && req[i] && (hold_q[i] == HLAST);
      ovf_hit[i]   = push[i] && full[i] && !retire[i];

      if (gnt[i] && req[i]) begin
        hold_d[i] = retire[i] ? '0 : hold_q[i] + HW'(1);
      end else if (short_hit[i]) begin
        hold_d[i] = '0;
      end

      if (push[i] && !ovf_hit[i] && !retire[i]) begin
        pending_d[i] = pending_q[i] + CW'(1);
      end else if (retire[i] && !push[i]) begin
        pending_d[i] = pending_q[i] - CW'(1);
      end
    end
  end

  // Clearing the lowest set bit leaves something only if two or more bits
  // were set, which flags a multi-grant without a full popcount.
  assign multi_hit = |(gnt & (gnt - N'(1)));

  // Job counters, slot counters and the registered retire pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      hold_q    <= '0;
      done      <= '0;
    end else begin
      pending_q <= pending_d;
      hold_q    <= hold_d;
      done      <= retire;
    end
  end

  // Sticky protocol error flags: a new error in the same cycle as clr_err
  // takes priority so that no violation is ever lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_multi    <= 1'b0;
      err_spurious <= 1'b0;
      err_short    <= 1'b0;
      err_ovf      <= 1'b0;
    end else begin
      err_multi    <= multi_hit     ? 1'b1 : (clr_err ? 1'b0 : err_multi);
      err_spurious <= (|spur_hit)   ? 1'b1 : (clr_err ? 1'b0 : err_spurious);
      err_short    <= (|short_hit)  ? 1'b1 : (clr_err ? 1'b0 : err_short);
      err_ovf      <= (|ovf_hit)    ? 1'b1 : (clr_err ? 1'b0 : err_ovf);
    end
  end

endmodule

// File: tb/tb_rr_request_agent.sv
// tb_rr_request_agent
//
// Bench for rr_request_agent. Directed scenarios walk through the normal
// slot flow, rotation, overflow, short/spurious/multi grants and an
// asynchronous reset mid-slot; a randomized phase follows. Expected values
// come from a job-queue model: each client holds a queue of job ids and a
// count of consecutive granted cycles in the current slot.

module tb_rr_request_agent;

  localparam int N    = 4;
  localparam int CW   = 3;
  localparam int SLOT = 4;
  localparam int PMAX = (1 << CW) - 1;

  logic         clk;
  logic         rst;
  logic [N-1:0] push;
  logic [N-1:0] full;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic [N-1:0] done;
  logic [N-1:0] busy;
  logic         clr_err;
  logic         err_multi;
  logic         err_spurious;
  logic         err_short;
  logic         err_ovf;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  int           jobs[N][$];
  int           run[N];
  int           next_id = 0;
  logic [N-1:0] m_done;
  logic         m_multi, m_spur, m_short, m_ovf;

  rr_request_agent #(.N(N), .CW(CW), .SLOT(SLOT)) dut (
    .clk          (clk),
    .rst          (rst),
    .push         (push),
    .full         (full),
    .req          (req),
    .gnt          (gnt),
    .done         (done),
    .busy         (busy),
    .clr_err      (clr_err),
    .err_multi    (err_multi),
    .err_spurious (err_spurious),
    .err_short    (err_short),
    .err_ovf      (err_ovf)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One counted comparison.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      jobs[i].delete();
      run[i] = 0;
    end
    m_done  = '0;
    m_multi = 1'b0;
    m_spur  = 1'b0;
    m_short = 1'b0;
    m_ovf   = 1'b0;
  endtask

  // Advance the model by one clock edge with the given inputs.
  task automatic model_step(input logic [N-1:0] p, input logic [N-1:0] g, input logic c);
    logic [N-1:0] nd;
    bit s_multi, s_spur, s_short, s_ovf;
    nd = '0;
    s_multi = ($countones(g) > 1);
    s_spur = 0; s_short = 0; s_ovf = 0;
    for (int i = 0; i < N; i++) begin
      bit ret;
      ret = 0;
      if (g[i]) begin
        if (jobs[i].size() == 0) begin
          s_spur = 1;
        end else begin
          run[i]++;
          if (run[i] == SLOT) begin
            ret = 1;
            run[i] = 0;
          end
        end
      end else if (run[i] != 0) begin
        s_short = 1;
        run[i] = 0;
      end
      if (p[i]) begin
        if (jobs[i].size() < PMAX || ret) begin
          jobs[i].push_back(next_id);
          next_id++;
        end else begin
          s_ovf = 1;
        end
      end
      if (ret) begin
        void'(jobs[i].pop_front());
        nd[i] = 1'b1;
      end
    end
    m_done  = nd;
    m_multi = s_multi ? 1'b1 : (c ? 1'b0 : m_multi);
    m_spur  = s_spur  ? 1'b1 : (c ? 1'b0 : m_spur);
    m_short = s_short ? 1'b1 : (c ? 1'b0 : m_short);
    m_ovf   = s_ovf   ? 1'b1 : (c ? 1'b0 : m_ovf);
  endtask

  // Compare every DUT output against the model.
  task automatic checkOutput();
    logic [N-1:0] e_req, e_full, e_busy;
    for (int i = 0; i < N; i++) begin
      e_req[i]  = (jobs[i].size() != 0);
      e_full[i] = (jobs[i].size() == PMAX);
      e_busy[i] = (run[i] != 0);
    end
    chk("req",          32'(req),          32'(e_req));
    chk("full",         32'(full),         32'(e_full));
    chk("busy",         32'(busy),         32'(e_busy));
    chk("done",         32'(done),         32'(m_done));
    chk("err_multi",    32'(err_multi),    32'(m_multi));
    chk("err_spurious", 32'(err_spurious), 32'(m_spur));
    chk("err_short",    32'(err_short),    32'(m_short));
    chk("err_ovf",      32'(err_ovf),      32'(m_ovf));
  endtask

  // Drive one cycle of inputs, let the edge happen, then compare.
  task automatic applyStimulus(input logic [N-1:0] p, input logic [N-1:0] g, input logic c);
    push    = p;
    gnt     = g;
    clr_err = c;
    @(posedge clk);
    if (rst) model_reset();
    else     model_step(p, g, c);
    #1;
    checkOutput();
  endtask

  initial begin
    logic [N-1:0] g_prev;
    logic [N-1:0] g_next;
    int           r;

    push = '0; gnt = '0; clr_err = 1'b0; rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput();
    rst = 1'b0;

    // Single job for client 0, served by one full slot.
    applyStimulus(4'b0001, 4'b0000, 1'b0);
    chk("s1_req", 32'(req), 32'h1);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    repeat (SLOT - 1) applyStimulus(4'b0000, 4'b0001, 1'b0);
    chk("s1_busy", 32'(busy[0]), 32'h1);
    applyStimulus(4'b0000, 4'b0001, 1'b0);
    chk("s1_done", 32'(done), 32'h1);
    chk("s1_req_clear", 32'(req), 32'h0);
    applyStimulus(4'b0000, 4'b0000, 1'b0);

    // Two jobs each on clients 1..3, rotated slots 1->2->3 twice.
    applyStimulus(4'b1110, 4'b0000, 1'b0);
    applyStimulus(4'b1110, 4'b0000, 1'b0);
    chk("s2_req", 32'(req), 32'hE);
    for (int rnd = 0; rnd < 2; rnd++)
      for (int c = 1; c < N; c++)
        repeat (SLOT) applyStimulus(4'b0000, N'(1 << c), 1'b0);
    chk("s2_req_final", 32'(req), 32'h0);
    applyStimulus(4'b0000, 4'b0000, 1'b0);

    // Fill client 2, overflow, then push on a retire cycle.
    repeat (PMAX) applyStimulus(4'b0100, 4'b0000, 1'b0);
    chk("s3_full", 32'(full[2]), 32'h1);
    applyStimulus(4'b0100, 4'b0000, 1'b0);
    chk("s3_ovf", 32'(err_ovf), 32'h1);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    repeat (SLOT - 1) applyStimulus(4'b0000, 4'b0100, 1'b0);
    applyStimulus(4'b0100, 4'b0100, 1'b0);
    chk("s3_ovf_on_retire", 32'(err_ovf), 32'h0);
    chk("s3_full_kept", 32'(full[2]), 32'h1);
    repeat (PMAX * SLOT) applyStimulus(4'b0000, 4'b0100, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 1'b0);

    // Short grant on client 0, clear, then a proper slot.
    applyStimulus(4'b0001, 4'b0000, 1'b0);
    repeat (2) applyStimulus(4'b0000, 4'b0001, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    chk("s4_short", 32'(err_short), 32'h1);
    chk("s4_req0", 32'(req[0]), 32'h1);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    chk("s4_clr", 32'(err_short), 32'h0);
    repeat (SLOT) applyStimulus(4'b0000, 4'b0001, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 1'b0);

    // Spurious grant, then a multi-grant with both clients pending.
    applyStimulus(4'b0000, 4'b0100, 1'b0);
    chk("s5_spur", 32'(err_spurious), 32'h1);
    applyStimulus(4'b0011, 4'b0000, 1'b0);
    repeat (SLOT) applyStimulus(4'b0000, 4'b0011, 1'b0);
    chk("s5_multi", 32'(err_multi), 32'h1);
    chk("s5_done_both", 32'(done), 32'h3);
    applyStimulus(4'b0000, 4'b0000, 1'b1);

    // Asynchronous reset in the middle of a slot.
    repeat (3) applyStimulus(4'b0010, 4'b0000, 1'b0);
    repeat (2) applyStimulus(4'b0000, 4'b0010, 1'b0);
    gnt = '0;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    checkOutput();
    chk("s6_req_async", 32'(req), 32'h0);
    chk("s6_busy_async", 32'(busy), 32'h0);
    @(posedge clk);
    #1;
    checkOutput();
    rst = 1'b0;
    applyStimulus(4'b0010, 4'b0000, 1'b0);
    repeat (SLOT) applyStimulus(4'b0000, 4'b0010, 1'b0);
    chk("s6_resume_done", 32'(done), 32'h2);

    // Randomized traffic: mostly sticky grants, with occasional changes.
    g_prev = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      r = $urandom_range(0, 9);
      if (r <= 5)       g_next = g_prev;
      else if (r <= 7)  g_next = N'(1 << $urandom_range(0, N - 1));
      else if (r == 8)  g_next = '0;
      else              g_next = N'($urandom_range(0, 15));
      applyStimulus(N'($urandom_range(0, 15) & $urandom_range(0, 15)), g_next,
                    ($urandom_range(0, 15) == 0));
      g_prev = g_next;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_request_agent.md
Name: rr_request_agent

Overview:
- Client-side counterpart of the 4-way round-robin fixed-time arbiter: it holds per-client job queues, drives the arbiter's req vector, and consumes its gnt vector.
- Each queued job needs exactly one full grant slot of SLOT consecutive cycles. The agent retires the job when the slot completes, and checks that the arbiter obeys the grant protocol.
- The block sits between the client logic (push/done) and the arbiter (req/gnt).

Parameters:
N, 4, number of clients (req/gnt width)
CW, 3, pending-job counter width per client; max pending = 2^CW-1
SLOT, 4, grant slot length in cycles (must match the arbiter's fixed time slice, >=1)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
push  input  N  per-client: enqueue one job this cycle
full  output  N  per-client: pending count == 2^CW-1
req  output  N  to arbiter: req[i] = (pending[i] != 0)
gnt  input  N  from arbiter grant vector
done  output  N  per-client 1-cycle pulse: job retired this cycle
busy  output  N  per-client: inside a grant slot (hold count != 0)
clr_err  input  1  synchronous clear of all sticky error flags
err_multi  output  1  sticky: gnt had more than one bit set
err_spurious  output  1  sticky: gnt[i] while pending[i]==0
err_short  output  1  sticky: gnt[i] dropped before SLOT cycles elapsed
err_ovf  output  1  sticky: push[i] while full[i]

Behaviour:
- Reset (async, any time including mid-slot):
  - pending, hold counters, done and all err_* go to 0 immediately; req=0, full=0, busy=0.
  - In-flight jobs are discarded.
- Per client i, state = pending[i] (CW bits) + hold[i] (0..SLOT-1). req, full and busy are decoded combinationally from registered state; they carry no extra latency.
- Grant counting:
  - Cycle with gnt[i]=1 and pending[i]!=0: if hold[i]==SLOT-1, the job retires: done[i]=1 next cycle (registered pulse), pending[i] decrements, hold[i] returns to 0. Otherwise hold[i] increments.
  - SLOT=1: every granted cycle retires one job.
- Back-to-back slots: req stays high while pending[i]>1 after retire. The arbiter may re-grant the same client; a fresh count starts from hold=0.
- Last job: req[i] falls the cycle after the retiring edge (pending becomes 0).
- Short grant: gnt[i]=0 while hold[i]!=0 → err_short=1, hold[i]=0, job NOT retired (remains pending, req stays high).
- Spurious grant: gnt[i]=1 while pending[i]==0 → err_spurious=1, grant ignored, no state change.
- Multi grant: gnt has more than one bit set (popcount>1) → err_multi=1. Each granted client is still counted independently, so the checker does not mask behaviour.
- Push:
  - push[i] with pending not full → pending+1.
  - Push and retire in the same cycle → pending unchanged, done pulses.
  - Push while full and not retiring → dropped, err_ovf=1.
  - Push while full and retiring in the same cycle → accepted (net unchanged).
- Sticky errors hold until rst or clr_err. If clr_err and a new error occur in the same cycle, the set wins.
- gnt=0 with pending!=0 and hold==0: idle wait, no error; req held high indefinitely.

Test Plan:
- SLOT=4, push[0] once at cycle 2 → req=0001 from cycle 3; gnt=0001 for cycles 5-8 → busy[0]=1 during cycles 6-8; done[0] pulses at cycle 9; req=0000 at cycle 9; no errors.
- Push 2 jobs each to clients 1,2,3 (req=1110); arbiter rotates 4-cycle slots 1→2→3→1→2→3 → six done pulses in rotation order; req clears per client after its second retire; final req=0000.
- Push client 2 seven times (CW=3) → full[2]=1, pending=7. 8th push → err_ovf=1, pending stays 7. Push together with a retire cycle → pending stays 7, no new error.
- Grant client 0 for only 2 cycles then gnt=0 → err_short=1, done never pulses, req[0] still 1. clr_err → err_short=0. Full 4-cycle grant → done[0].
- gnt=0100 with pending[2]=0 → err_spurious=1, no done. gnt=0011 with both pending → err_multi=1.
- Assert rst at hold[1]=2 with pending[1]=3 → req, busy, pending go to 0 immediately, no done pulse. After release, push → normal operation resumes.
